// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the memory stage: opcodes, access sizes,
// writeback source selects, FSM states and the writeback context record.
package rv32i_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] SRC_MEM = 2'd0;
  localparam logic [1:0] SRC_IO  = 2'd1;
  localparam logic [1:0] SRC_ALU = 2'd2;

  typedef enum logic {IDLE, IO_WAIT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] iw;
    logic [31:0] alu;
    logic [4:0]  wb_reg;
    logic        wb_en;
    logic [1:0]  src_sel;
  } wb_ctx_t;

  localparam wb_ctx_t CTX_BUBBLE = '{pc: '0, iw: '0, alu: '0, wb_reg: '0,
                                     wb_en: 1'b0, src_sel: SRC_ALU};

endpackage

// File: rtl/rv32i_store_align.sv
// Byte-enable and store-lane alignment for byte/half/word accesses, with
// misalignment detection (enables are forced off on a misaligned access).
module rv32i_store_align
  import rv32i_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned
);

  // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    o_misaligned = 1'b0;
    o_be         = 4'b1111;
    case (i_size)
      SZ_B: o_be = 4'b0001 << i_off;
      SZ_H: begin
        o_be         = 4'b0011 << i_off;
        o_misaligned = i_off[0];
      end
      default: o_misaligned = (i_off != 2'b00);
    endcase
    if (o_misaligned) o_be = 4'b0000;
    o_wdata = i_data << {i_off, 3'b000};
  end

endmodule

// File: rtl/rv32i_mem_stage.sv
// RV32I memory-access stage: steers loads/stores to data RAM or IO space,
// runs the IO req/ack handshake and registers the writeback context.
module rv32i_mem_stage
  import rv32i_pkg::*;
#(
  parameter int          MEM_ADDR_W = 14,
  parameter logic [31:0] IO_BASE    = 32'h0002_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [31:0]           pc_in,
  input  logic [31:0]           iw_in,
  input  logic [31:0]           alu_in,
  input  logic [31:0]           rs2_data_in,
  input  logic [4:0]            wb_reg_in,
  input  logic                  wb_en_in,
  output logic                  stall_out,
  output logic [MEM_ADDR_W-1:0] memif_addr,
  output logic                  memif_we,
  output logic [3:0]            memif_be,
  output logic [31:0]           memif_wdata,
  output logic                  io_req,
  output logic                  io_we,
  output logic [31:0]           io_addr,
  output logic [3:0]            io_be,
  output logic [31:0]           io_wdata,
  input  logic                  io_ack,
  output logic [31:0]           pc_out,
  output logic [31:0]           iw_out,
  output logic [31:0]           alu_out,
  output logic [4:0]            wb_reg_out,
  output logic                  wb_en_out,
  output logic [1:0]            src_sel_out,
  output logic                  misalign_err,
  output logic                  df_mem_enable,
  output logic [4:0]            df_mem_reg,
  output logic [31:0]           df_mem_data
);

  state_t      r_state, w_state_next;
  wb_ctx_t     r_ctx, w_ctx_next, w_in_ctx, r_hold_ctx;
  logic        r_misalign, w_misalign_next;
  logic        r_hold_we, w_capture;
  logic [3:0]  r_hold_be;
  logic [31:0] r_hold_wdata;

  logic        w_is_load, w_is_store, w_is_mem, w_is_io, w_misaligned, w_io_start;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  assign w_is_load  = valid_in && (iw_in[6:0] == OP_LOAD);
  assign w_is_store = valid_in && (iw_in[6:0] == OP_STORE);
  assign w_is_mem   = w_is_load || w_is_store;
  assign w_is_io    = (alu_in[31:16] == IO_BASE[31:16]);
  assign w_io_start = w_is_mem && w_is_io && !w_misaligned;

  rv32i_store_align u_align (
    .i_size       (iw_in[13:12]),
    .i_off        (alu_in[1:0]),
    .i_data       (rs2_data_in),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned)
  );

  // RAM port is combinational; IO-space stores never strobe the RAM.
  assign memif_addr  = alu_in[MEM_ADDR_W+1:2];
  assign memif_wdata = w_wdata;
  assign memif_we    = w_is_store && !w_is_io && !w_misaligned && !stall_out;
  assign memif_be    = memif_we ? w_be : 4'b0000;

  always_comb begin
    w_in_ctx = CTX_BUBBLE;
    if (valid_in) begin
      w_in_ctx.pc      = pc_in;
      w_in_ctx.iw      = iw_in;
      w_in_ctx.alu     = alu_in;
      w_in_ctx.wb_reg  = wb_reg_in;
      w_in_ctx.wb_en   = wb_en_in && !(w_is_mem && w_misaligned);
      w_in_ctx.src_sel = w_is_load ? (w_is_io ? SRC_IO : SRC_MEM) : SRC_ALU;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_ctx_next      = w_in_ctx;
    w_misalign_next = 1'b0;
    w_capture       = 1'b0;
    stall_out       = 1'b0;
    io_req          = 1'b0;
    io_we           = 1'b0;
    io_addr         = alu_in;
    io_be           = 4'b0000;
    io_wdata        = w_wdata;
    case (r_state)
      IDLE: begin
        w_misalign_next = w_is_mem && w_misaligned;
        if (w_io_start) begin
          io_req = 1'b1;
          io_we  = w_is_store;
          io_be  = w_be;
          // An access not acknowledged immediately is parked and the slot bubbles.
          if (!io_ack) begin
            w_state_next = IO_WAIT;
            w_ctx_next   = CTX_BUBBLE;
            w_capture    = 1'b1;
          end
        end
      end
      IO_WAIT: begin
        stall_out  = 1'b1;
        io_req     = 1'b1;
        io_we      = r_hold_we;
        io_addr    = r_hold_ctx.alu;
        io_be      = r_hold_be;
        io_wdata   = r_hold_wdata;
        w_ctx_next = io_ack ? r_hold_ctx : CTX_BUBBLE;
        if (io_ack) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_ctx      <= CTX_BUBBLE;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ctx      <= w_ctx_next;
      r_misalign <= w_misalign_next;
    end
  end

  // NOTE: the parked-access copy is only read in IO_WAIT, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_hold_ctx   <= w_in_ctx;
      r_hold_we    <= w_is_store;
      r_hold_be    <= w_be;
      r_hold_wdata <= w_wdata;
    end
  end

  assign pc_out        = r_ctx.pc;
  assign iw_out        = r_ctx.iw;
  assign alu_out       = r_ctx.alu;
  assign wb_reg_out    = r_ctx.wb_reg;
  assign wb_en_out     = r_ctx.wb_en;
  assign src_sel_out   = r_ctx.src_sel;
  assign misalign_err  = r_misalign;
  assign df_mem_enable = r_ctx.wb_en;
  assign df_mem_reg    = r_ctx.wb_reg;
  assign df_mem_data   = r_ctx.alu;

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// Self-checking bench for rv32i_mem_stage: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_rv32i_mem_stage;

  logic        clk = 1'b0;
  logic        reset, valid_in, wb_en_in, io_ack;
  logic [31:0] pc_in, iw_in, alu_in, rs2_data_in;
  logic [4:0]  wb_reg_in;
  logic        stall_out, memif_we, io_req, io_we, wb_en_out, misalign_err, df_mem_enable;
  logic [13:0] memif_addr;
  logic [3:0]  memif_be, io_be;
  logic [31:0] memif_wdata, io_addr, io_wdata, pc_out, iw_out, alu_out, df_mem_data;
  logic [4:0]  wb_reg_out, df_mem_reg;
  logic [1:0]  src_sel_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32i_mem_stage #(.MEM_ADDR_W(14), .IO_BASE(32'h0002_0000)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in), .iw_in(iw_in),
    .alu_in(alu_in), .rs2_data_in(rs2_data_in), .wb_reg_in(wb_reg_in), .wb_en_in(wb_en_in),
    .stall_out(stall_out), .memif_addr(memif_addr), .memif_we(memif_we), .memif_be(memif_be),
    .memif_wdata(memif_wdata), .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
    .io_be(io_be), .io_wdata(io_wdata), .io_ack(io_ack), .pc_out(pc_out), .iw_out(iw_out),
    .alu_out(alu_out), .wb_reg_out(wb_reg_out), .wb_en_out(wb_en_out),
    .src_sel_out(src_sel_out), .misalign_err(misalign_err), .df_mem_enable(df_mem_enable),
    .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_iw(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {17'h0, f3, rd, op};
  endfunction

  task automatic put(input logic v, input logic [31:0] pc, input logic [31:0] iw,
                     input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                     input logic wen, input logic ack);
    @(posedge clk);
    #1;
    valid_in = v; pc_in = pc; iw_in = iw; alu_in = alu; rs2_data_in = rs2;
    wb_reg_in = rd; wb_en_in = wen; io_ack = ack;
  endtask

  // ---------------- behavioural model and per-cycle compare ----------------
  typedef struct {
    logic        is_real;
    logic [31:0] pc, iw, alu;
    logic [4:0]  rd;
    logic        wen;
    logic [1:0]  src;
  } exp_t;

  exp_t        m_out;
  logic        m_mis, m_known = 1'b0, m_wait = 1'b0;
  exp_t        h_ent;
  logic        h_we;
  logic [3:0]  h_be;
  logic [31:0] h_wdata;

  always @(negedge clk) begin : model
    logic       ld, st, io, mis, ioreq, e_we;
    logic [1:0] sz, off;
    logic [3:0] be_nat;
    logic [31:0] wd;
    exp_t cur, bub, nxt;
    logic n_mis;

    ld     = valid_in && iw_in[6:0] == 7'h03;
    st     = valid_in && iw_in[6:0] == 7'h23;
    sz     = iw_in[13:12];
    off    = alu_in[1:0];
    io     = alu_in[31:16] == 16'h0002;
    mis    = (ld || st) && ((sz == 2'd1 && off[0]) || (sz != 2'd0 && sz != 2'd1 && off != 2'd0));
    be_nat = (sz == 2'd0) ? (4'b0001 << off) : (sz == 2'd1) ? (4'b0011 << off) : 4'b1111;
    wd     = rs2_data_in << (8 * off);
    ioreq  = !m_wait && (ld || st) && io && !mis;
    e_we   = !m_wait && st && !io && !mis;

    if (m_known) begin
      check("m_wb_en", 32'(wb_en_out), 32'(m_out.wen));
      check("m_src", 32'(src_sel_out), 32'(m_out.src));
      check("m_df_en", 32'(df_mem_enable), 32'(m_out.wen));
      check("m_misalign", 32'(misalign_err), 32'(m_mis));
      if (m_out.is_real) begin
        check("m_pc", pc_out, m_out.pc);
        check("m_iw", iw_out, m_out.iw);
        check("m_alu", alu_out, m_out.alu);
        check("m_rd", 32'(wb_reg_out), 32'(m_out.rd));
        check("m_df_data", df_mem_data, m_out.alu);
      end
      check("m_stall", 32'(stall_out), 32'(m_wait));
      check("m_io_req", 32'(io_req), 32'(m_wait || ioreq));
      if (m_wait) begin
        check("m_io_we_h", 32'(io_we), 32'(h_we));
        check("m_io_addr_h", io_addr, h_ent.alu);
        check("m_io_be_h", 32'(io_be), 32'(h_be));
        if (h_we) check("m_io_wdata_h", io_wdata, h_wdata);
      end else if (ioreq) begin
        check("m_io_we", 32'(io_we), 32'(st));
        check("m_io_addr", io_addr, alu_in);
        check("m_io_be", 32'(io_be), 32'(be_nat));
        if (st) check("m_io_wdata", io_wdata, wd);
      end
      check("m_mem_we", 32'(memif_we), 32'(e_we));
      check("m_mem_be", 32'(memif_be), e_we ? 32'(be_nat) : 32'h0);
      check("m_mem_addr", 32'(memif_addr), 32'(alu_in[15:2]));
      if (e_we) check("m_mem_wdata", memif_wdata, wd);
    end

    bub = '{is_real: 1'b0, pc: '0, iw: '0, alu: '0, rd: '0, wen: 1'b0, src: 2'd2};
    cur = '{is_real: 1'b1, pc: pc_in, iw: iw_in, alu: alu_in, rd: wb_reg_in,
            wen: wb_en_in && !mis, src: ld ? (io ? 2'd1 : 2'd0) : 2'd2};
    nxt   = bub;
    n_mis = 1'b0;
    if (!reset) begin
      m_wait = 1'b0;
    end else if (m_wait) begin
      if (io_ack) begin
        nxt    = h_ent;
        m_wait = 1'b0;
      end
    end else begin
      n_mis = mis;
      if (ioreq && !io_ack) begin
        m_wait  = 1'b1;
        h_ent   = cur;
        h_we    = st;
        h_be    = be_nat;
        h_wdata = wd;
      end else if (valid_in) begin
        nxt = cur;
      end
    end
    m_out = nxt;
    m_mis = n_mis;
    if (!reset) m_known = 1'b1;
  end

  // ---------------- stimulus ----------------
  initial begin
    int req_cnt, stall_cnt, wc;
    logic [31:0] r, a;
    logic [1:0]  sz, off;
    logic [6:0]  op;
    int kind;

    reset = 1'b0; valid_in = 1'b0; pc_in = '0; iw_in = '0; alu_in = '0;
    rs2_data_in = '0; wb_reg_in = '0; wb_en_in = 1'b0; io_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_src", 32'(src_sel_out), 32'd2);
    check("rst_wb_en", 32'(wb_en_out), 32'd0);
    check("rst_stall", 32'(stall_out), 32'd0);
    reset = 1'b1;

    // sw / sb / sh lane alignment into RAM
    put(1, 32'h10, mk_iw(7'h23, 3'b010, 5'd0), 32'h100, 32'hDEADBEEF, 5'd0, 0, 0);
    #2;
    check("sw_we", 32'(memif_we), 32'd1);
    check("sw_addr", 32'(memif_addr), 32'h40);
    check("sw_be", 32'(memif_be), 32'hF);
    check("sw_wdata", memif_wdata, 32'hDEADBEEF);
    check("sw_stall", 32'(stall_out), 32'd0);
    put(1, 32'h14, mk_iw(7'h23, 3'b000, 5'd0), 32'h103, 32'h000000AB, 5'd0, 0, 0);
    check("sw_src", 32'(src_sel_out), 32'd2);
    #2;
    check("sb_be", 32'(memif_be), 32'h8);
    check("sb_wdata", memif_wdata, 32'hAB000000);
    put(1, 32'h18, mk_iw(7'h23, 3'b001, 5'd0), 32'h102, 32'h00001234, 5'd0, 0, 0);
    #2;
    check("sh_be", 32'(memif_be), 32'hC);
    check("sh_wdata", memif_wdata, 32'h12340000);

    // IO load acknowledged three cycles later
    put(1, 32'h20, mk_iw(7'h03, 3'b010, 5'd3), 32'h0002_0010, 32'h0, 5'd3, 1, 0);
    #2;
    check("io_req0", 32'(io_req), 32'd1);
    check("io_addr0", io_addr, 32'h0002_0010);
    req_cnt = int'(io_req); stall_cnt = int'(stall_out);
    for (int c = 1; c <= 3; c++) begin
      put(0, 0, 0, 0, 0, 0, 0, (c == 3));
      #2;
      req_cnt += int'(io_req); stall_cnt += int'(stall_out);
      check("io_bubble", 32'(wb_en_out), 32'd0);
    end
    put(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("io_src", 32'(src_sel_out), 32'd1);
    check("io_rd", 32'(wb_reg_out), 32'd3);
    check("io_wb_en", 32'(wb_en_out), 32'd1);
    check("io_stall_end", 32'(stall_out), 32'd0);
    check("io_req_cycles", 32'(req_cnt), 32'd4);
    check("io_stall_cycles", 32'(stall_cnt), 32'd3);
    put(0, 0, 0, 0, 0, 0, 0, 0);
    check("io_one_cycle", 32'(wb_en_out), 32'd0);

    // misaligned word store
    put(1, 32'h30, mk_iw(7'h23, 3'b010, 5'd0), 32'h102, 32'h55AA55AA, 5'd4, 1, 0);
    #2;
    check("mis_be", 32'(memif_be), 32'h0);
    check("mis_we", 32'(memif_we), 32'd0);
    check("mis_io_req", 32'(io_req), 32'd0);
    put(0, 0, 0, 0, 0, 0, 0, 0);
    check("mis_err", 32'(misalign_err), 32'd1);
    check("mis_wb_en", 32'(wb_en_out), 32'd0);
    put(0, 0, 0, 0, 0, 0, 0, 0);
    check("mis_pulse", 32'(misalign_err), 32'd0);

    // reset while waiting on IO
    put(1, 32'h40, mk_iw(7'h03, 3'b010, 5'd9), 32'h0002_0020, 32'h0, 5'd9, 1, 0);
    put(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("rw_stall", 32'(stall_out), 32'd1);
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    #2;
    check("rw_io_req", 32'(io_req), 32'd0);
    check("rw_stall0", 32'(stall_out), 32'd0);
    check("rw_wb_en", 32'(wb_en_out), 32'd0);
    check("rw_src", 32'(src_sel_out), 32'd2);
    put(1, 32'h44, mk_iw(7'h03, 3'b010, 5'd7), 32'h200, 32'h0, 5'd7, 1, 0);
    #2;
    check("rw_lw_req", 32'(io_req), 32'd0);
    put(0, 0, 0, 0, 0, 0, 0, 0);
    check("rw_lw_src", 32'(src_sel_out), 32'd0);
    check("rw_lw_rd", 32'(wb_reg_out), 32'd7);

    // back-to-back add then RAM load, forwarding view
    put(1, 32'h50, mk_iw(7'h33, 3'b000, 5'd5), 32'h7, 32'h0, 5'd5, 1, 0);
    put(1, 32'h54, mk_iw(7'h03, 3'b010, 5'd6), 32'h300, 32'h0, 5'd6, 1, 0);
    check("fw_reg", 32'(df_mem_reg), 32'd5);
    check("fw_data", df_mem_data, 32'd7);
    check("fw_en", 32'(df_mem_enable), 32'd1);
    put(0, 0, 0, 0, 0, 0, 0, 0);
    check("fw_lw_src", 32'(src_sel_out), 32'd0);

    // randomized traffic, upstream holds while stalled
    wc = 0;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #1;
      if (stall_out) wc++; else wc = 0;
      if (!stall_out) begin
        kind = $urandom_range(0, 9);
        sz   = 2'($urandom_range(0, 2));
        off  = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) off = (sz == 2'd2) ? 2'd0 : (sz == 2'd1) ? (off & 2'b10) : off;
        a = $urandom;
        a = ($urandom_range(0, 2) == 0) ? {16'h0002, a[15:2], off} : {16'h0000, a[15:2], off};
        op = (kind <= 3) ? 7'h03 : (kind <= 6) ? 7'h23 : 7'h33;
        r = $urandom;
        r[6:0] = op;
        r[14:12] = {1'b0, sz};
        valid_in    = (kind != 9);
        pc_in       = $urandom;
        iw_in       = r;
        alu_in      = a;
        rs2_data_in = $urandom;
        wb_reg_in   = 5'($urandom);
        wb_en_in    = 1'($urandom);
      end
      io_ack = ($urandom_range(0, 2) == 0) || (wc >= 4);
      reset  = ($urandom_range(0, 79) != 0);
    end

    reset = 1'b1;
    repeat (4) put(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_mem_stage.md
Name: rv32i_mem_stage

Overview:
- Memory-access stage of the RV32I pipeline. Sits between the execute stage and the writeback stage.
- Decodes the load/store in the incoming instruction and steers it to data RAM or IO space.
- Generates byte enables and lane-aligned store data, and runs a request/acknowledge handshake with the IO block (stalling upstream while it waits).
- Registers the instruction context and the 2-bit writeback source select that the writeback stage consumes.

Parameters:
- MEM_ADDR_W, 14, word-address width of the data RAM port.
- IO_BASE, 32'h0002_0000, base of IO space; an access is IO when addr[31:16] == IO_BASE[31:16].

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk rising edge)
- valid_in  in  1  execute stage presents a valid instruction
- pc_in, iw_in, alu_in  in  32 each  PC, instruction word, ALU result / effective address
- rs2_data_in  in  32  store source data
- wb_reg_in  in  5  destination register
- wb_en_in  in  1  destination write enable
- stall_out  out  1  hold upstream stage
- memif_addr  out  MEM_ADDR_W  RAM word address (= alu_in[MEM_ADDR_W+1:2])
- memif_we  out  1  RAM write strobe
- memif_be  out  4  RAM byte enables
- memif_wdata  out  32  RAM write data
- io_req  out  1  IO request
- io_we  out  1  IO write
- io_addr  out  32  IO byte address
- io_be  out  4  IO byte enables
- io_wdata  out  32  IO write data
- io_ack  in  1  IO accepts request
- pc_out, iw_out, alu_out  out  32 each  registered context to writeback
- wb_reg_out  out  5  registered destination register
- wb_en_out  out  1  registered write enable
- src_sel_out  out  2  0 = RAM read data, 1 = IO read data, 2 = ALU
- misalign_err  out  1  one-cycle pulse on a misaligned access
- df_mem_enable  out  1  forwarding: wb_en_out
- df_mem_reg  out  5  forwarding: wb_reg_out
- df_mem_data  out  32  forwarding: alu_out

Behaviour:
- Decode:
  - LOAD is opcode 7'b0000011; STORE is 7'b0100011.
  - Size comes from iw_in[13:12]: 00 = byte, 01 = half, 10 = word.
- Byte enables, with off = alu_in[1:0]:
  - byte: 4'b0001 << off
  - half: 4'b0011 << off
  - word: 4'b1111
- Store data is rs2_data_in shifted left by 8*off.
- Misaligned access (half with off[0]=1, word with off != 0):
  - be forced 0, no write, no io_req.
  - misalign_err=1 in the following cycle.
  - wb_en_out=0 for that instruction.
- RAM path (non-IO):
  - memif_* driven combinationally in the same cycle.
  - memif_we = valid_in & STORE & aligned & !stall_out.
  - memif_be is 0 for loads and for non-memory instructions.
- FSM:
  - IDLE:
    - IO load/store with valid_in: io_req=1, io_* driven from current inputs.
    - If io_ack is seen in the same cycle, the access completes there; otherwise go to IO_WAIT with stall_out=1.
  - IO_WAIT:
    - io_req, io_we, io_addr, io_be, io_wdata held stable from internally latched copies.
    - stall_out=1; the output register inserts a bubble (wb_en_out=0, src_sel_out=2).
    - On io_ack=1: return to IDLE, deassert stall_out next cycle, and advance the held instruction into the output register that cycle.
- Output register:
  - Updates every cycle that is not a stall.
  - src_sel_out = 1 for an IO load, 0 for a RAM load, 2 otherwise.
  - valid_in=0 produces a bubble (wb_en_out=0).
- Latency: one cycle from input to output register. An IO access adds N stall cycles, where N = cycles until io_ack.
- Reset (reset==0):
  - All registered outputs 0 except src_sel_out=2. State goes to IDLE; io_req=0 and stall_out=0 next cycle.
  - Reset during IO_WAIT abandons the access.
- Load byte-lane extraction and sign extension are out of scope. They are done downstream using iw_out[14:12] and alu_out[1:0].

Decomposition:
- Shared package rv32i_pkg holds:
  - opcode constants OP_LOAD and OP_STORE
  - size encodings SZ_B, SZ_H, SZ_W
  - src_sel constants SRC_MEM=0, SRC_IO=1, SRC_ALU=2
  - FSM enum {IDLE, IO_WAIT}
- One combinational sub-module, rv32i_store_align, takes (size, off, data) and returns (be, wdata, misaligned).

Test Plan:
- sw at alu_in=0x100, rs2=0xDEADBEEF -> memif_we=1, memif_addr=0x40, be=1111, wdata=0xDEADBEEF, no stall, src_sel_out=2.
- sb at 0x103, rs2=0x000000AB -> be=1000, wdata=0xAB000000; sh at 0x102, rs2=0x1234 -> be=1100, wdata=0x12340000.
- lw at 0x0002_0010, io_ack after 3 cycles -> io_req held 4 cycles, stall_out=1 for 3 cycles, wb_en_out=0 bubbles, then src_sel_out=1 and wb_reg_out valid for one cycle.
- sw at 0x102 -> be=0, memif_we=0, misalign_err pulses one cycle, wb_en_out=0.
- reset=0 asserted in IO_WAIT -> next cycle io_req=0, stall_out=0, wb_en_out=0, src_sel_out=2; new lw at 0x200 after release gives src_sel_out=0.
- back-to-back add (wb_en_in=1, rd=5, alu=7) then lw RAM -> df_mem_reg=5, df_mem_data=7 in cycle 1, src_sel_out=0 in cycle 2.
